// File: rtl/pong_game_ctrl_pkg.sv
// Shared pong definitions: game state encodings, screen geometry, score format
// and the BCD increment used by the score counter.
package pong_game_ctrl_pkg;

  localparam logic [1:0] ST_NEWGAME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_NEWBALL = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  localparam int MAX_X     = 640;
  localparam int MAX_Y     = 480;
  localparam int REFR_LINE = 481;
  localparam int BCD_W     = 4;
  localparam int TIMER_W   = 7;

  typedef struct packed {
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } score_t;

  // Two-digit BCD increment; 99 wraps to 00 with no carry out.
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    r = s;
    if (s.d0 == BCD_W'(9)) begin
      r.d0 = '0;
      r.d1 = (s.d1 == BCD_W'(9)) ? '0 : s.d1 + BCD_W'(1);
    end else begin
      r.d0 = s.d0 + BCD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and the rest of the pong top
// level (sync generator, buttons, graph and text blocks).
interface pong_game_ctrl_if;
  import pong_game_ctrl_pkg::*;

  logic [9:0]       pix_x;
  logic [9:0]       pix_y;
  logic [1:0]       btn;
  logic             hit;
  logic             miss;
  logic             gra_still;
  logic [1:0]       game_state;
  logic [BCD_W-1:0] score_d1;
  logic [BCD_W-1:0] score_d0;
  logic [1:0]       balls_left;
  logic             timer_up;

  modport master (
    output pix_x, pix_y, btn, hit, miss,
    input  gra_still, game_state, score_d1, score_d0, balls_left, timer_up
  );

  modport slave (
    input  pix_x, pix_y, btn, hit, miss,
    output gra_still, game_state, score_d1, score_d0, balls_left, timer_up
  );

endinterface

// File: rtl/pong_frame_timer.sv
// Frame-rate pause timer: one refresh tick per frame, and a loadable 7-bit
// down counter that stops at zero.
module pong_frame_timer
  import pong_game_ctrl_pkg::*;
#(
  parameter int TIMER_TICKS = 120,
  parameter int REFR_LINE   = pong_game_ctrl_pkg::REFR_LINE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       load,
  output logic       timer_up
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;
  logic               refr_tick;

  assign refr_tick = (pix_y == 10'(REFR_LINE)) && (pix_x == 10'd0);

  // A load takes priority over a decrement landing on the same cycle.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = TIMER_W'(TIMER_TICKS);
    end else if (refr_tick && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timer_up = (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new game / play / new ball / game over, hit/miss edge
// detection, BCD score and remaining-ball count.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int NUM_BALLS   = 3,
  parameter int TIMER_TICKS = 120,
  parameter int REFR_LINE   = pong_game_ctrl_pkg::REFR_LINE
) (
  input logic              clk,
  input logic              reset,
  pong_game_ctrl_if.slave  bus
);

  logic [1:0] state_q, state_d;
  score_t     score_q, score_d;
  logic [1:0] balls_q, balls_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       hit_p, miss_p;
  logic       btn_any;
  logic       timer_load;
  logic       timer_up;

  // The graph block holds hit/miss for many cycles; only the first cycle counts.
  assign hit_d   = bus.hit;
  assign miss_d  = bus.miss;
  assign hit_p   = bus.hit & ~hit_q;
  assign miss_p  = bus.miss & ~miss_q;
  assign btn_any = (bus.btn != 2'b00);

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    balls_d    = balls_q;
    timer_load = 1'b0;
    case (state_q)
      ST_NEWGAME: begin
        score_d = '0;
        balls_d = 2'(NUM_BALLS);
        if (btn_any) begin
          state_d = ST_PLAY;
          balls_d = 2'(NUM_BALLS - 1);
        end
      end
      ST_PLAY: begin
        if (hit_p) begin
          score_d = bcd_inc(score_q);
        end else if (miss_p) begin
          timer_load = 1'b1;
          if (balls_q == 2'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_NEWBALL;
            balls_d = balls_q - 2'd1;
          end
        end
      end
      ST_NEWBALL: begin
        if (timer_up && btn_any) begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        // Score stays visible through the game-over pause.
        if (timer_up) begin
          state_d = ST_NEWGAME;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NEWGAME;
      score_q <= '0;
      balls_q <= 2'(NUM_BALLS);
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      balls_q <= balls_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  pong_frame_timer #(
    .TIMER_TICKS (TIMER_TICKS),
    .REFR_LINE   (REFR_LINE)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .pix_x    (bus.pix_x),
    .pix_y    (bus.pix_y),
    .load     (timer_load),
    .timer_up (timer_up)
  );

  assign bus.gra_still  = (state_q != ST_PLAY);
  assign bus.game_state = state_q;
  assign bus.score_d1   = score_q.d1;
  assign bus.score_d0   = score_q.d0;
  assign bus.balls_left = balls_q;
  assign bus.timer_up   = timer_up;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: reset, start, scoring and wrap, miss pause,
// simultaneous hit/miss, game over and reset during a pause.
module tb_pong_game_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .NUM_BALLS   (3),
    .TIMER_TICKS (120),
    .REFR_LINE   (481)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hit_pulse();
    bus.hit = 1'b1;
    repeat (3) clk1();
    bus.hit = 1'b0;
    clk1();
  endtask

  // One refresh tick per call, on consecutive cycles when called back to back.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pix_y = 10'd481;
      bus.pix_x = 10'd0;
      clk1();
      bus.pix_y = 10'd0;
      bus.pix_x = 10'd5;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.pix_x = 10'd5;
    bus.pix_y = 10'd0;
    bus.btn   = 2'b00;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    repeat (3) clk1();
    reset = 1'b0;

    // 1: reset values, idle frames with no button
    chk("rst_state", 32'(bus.game_state), 32'h0);
    chk("rst_still", 32'(bus.gra_still), 32'h1);
    chk("rst_score", {24'h0, bus.score_d1, bus.score_d0}, 32'h00);
    chk("rst_balls", 32'(bus.balls_left), 32'h3);
    chk("rst_tup", 32'(bus.timer_up), 32'h1);
    ticks(3);
    clk1();
    chk("idle_state", 32'(bus.game_state), 32'h0);
    chk("idle_balls", 32'(bus.balls_left), 32'h3);

    // 2: start
    bus.btn = 2'b01;
    clk1();
    bus.btn = 2'b00;
    chk("start_state", 32'(bus.game_state), 32'h1);
    chk("start_still", 32'(bus.gra_still), 32'h0);
    chk("start_balls", 32'(bus.balls_left), 32'h2);

    // 3: scoring, long hit level counts once, BCD carry and wrap
    bus.hit = 1'b1;
    repeat (50) clk1();
    bus.hit = 1'b0;
    clk1();
    chk("score_long_hit", {24'h0, bus.score_d1, bus.score_d0}, 32'h01);
    repeat (6) hit_pulse();
    chk("score_07", {24'h0, bus.score_d1, bus.score_d0}, 32'h07);
    repeat (3) hit_pulse();
    chk("score_10", {24'h0, bus.score_d1, bus.score_d0}, 32'h10);
    repeat (89) hit_pulse();
    chk("score_99", {24'h0, bus.score_d1, bus.score_d0}, 32'h99);
    hit_pulse();
    chk("score_wrap", {24'h0, bus.score_d1, bus.score_d0}, 32'h00);

    // 4: miss starts pause; hit and button ignored during it
    bus.miss = 1'b1;
    clk1();
    bus.miss = 1'b0;
    chk("miss_state", 32'(bus.game_state), 32'h2);
    chk("miss_balls", 32'(bus.balls_left), 32'h1);
    chk("miss_tup", 32'(bus.timer_up), 32'h0);
    chk("miss_still", 32'(bus.gra_still), 32'h1);
    hit_pulse();
    chk("nb_hit_ign", {24'h0, bus.score_d1, bus.score_d0}, 32'h00);
    bus.btn = 2'b01;
    ticks(119);
    chk("nb_119_state", 32'(bus.game_state), 32'h2);
    chk("nb_119_tup", 32'(bus.timer_up), 32'h0);
    ticks(1);
    chk("nb_120_state", 32'(bus.game_state), 32'h2);
    chk("nb_120_tup", 32'(bus.timer_up), 32'h1);
    clk1();
    bus.btn = 2'b00;
    chk("nb_resume", 32'(bus.game_state), 32'h1);

    // 5: simultaneous hit/miss edges, hit wins
    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    clk1();
    chk("both_score", {24'h0, bus.score_d1, bus.score_d0}, 32'h01);
    chk("both_state", 32'(bus.game_state), 32'h1);
    chk("both_balls", 32'(bus.balls_left), 32'h1);
    chk("both_tup", 32'(bus.timer_up), 32'h1);
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    clk1();

    // 6: last two balls, game over pause, return to new game
    bus.miss = 1'b1;
    clk1();
    bus.miss = 1'b0;
    chk("m2_balls", 32'(bus.balls_left), 32'h0);
    bus.btn = 2'b10;
    ticks(120);
    clk1();
    bus.btn = 2'b00;
    chk("m2_resume", 32'(bus.game_state), 32'h1);
    bus.miss = 1'b1;
    clk1();
    bus.miss = 1'b0;
    chk("over_state", 32'(bus.game_state), 32'h3);
    chk("over_balls", 32'(bus.balls_left), 32'h0);
    chk("over_tup", 32'(bus.timer_up), 32'h0);
    ticks(120);
    chk("over_hold", 32'(bus.game_state), 32'h3);
    chk("over_score", {24'h0, bus.score_d1, bus.score_d0}, 32'h01);
    clk1();
    chk("ng_state", 32'(bus.game_state), 32'h0);
    clk1();
    chk("ng_score", {24'h0, bus.score_d1, bus.score_d0}, 32'h00);
    chk("ng_balls", 32'(bus.balls_left), 32'h3);

    // Reset in the middle of a new-ball pause
    bus.btn = 2'b01;
    clk1();
    bus.btn = 2'b00;
    hit_pulse();
    bus.miss = 1'b1;
    clk1();
    bus.miss = 1'b0;
    ticks(10);
    chk("mid_state", 32'(bus.game_state), 32'h2);
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    chk("mrst_state", 32'(bus.game_state), 32'h0);
    chk("mrst_balls", 32'(bus.balls_left), 32'h3);
    chk("mrst_score", {24'h0, bus.score_d1, bus.score_d0}, 32'h00);
    chk("mrst_tup", 32'(bus.timer_up), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
